apb_ascon_csr: RTL and testbench
================================

// Module: apb_ascon_csr
// PURPOSE
//  Second-generation APB register bank that drives the Ascon wrapper: key/nonce/control
//  writes, status reads, AD/PT push, CT pop and tag capture.
//  New in this generation:
//  - bus width is a parameter
//  - wait-state back-pressure on full/empty FIFOs, with a timeout
//  - START is a self-clearing pulse; key/nonce/ctrl writes are locked while busy
//  - sticky interrupts with enable mask
//  The block sits between the subsystem APB interconnect and the Ascon wrapper.
// PARAMETERS
//  APB_AW      10  APB address width (bytes)
//  APB_DW      32  APB data width; legal values 32 or 64 (elaboration assert otherwise)
//  DATA_AW     7   width of ad_size_o / pt_size_o
//  DELAY_WIDTH 16  width of delay_o
//  WAIT_MAX    64  maximum wait states before a back-pressured access errors out
// PORTS
//  clk          in   1            clock, all logic on rising edge
//  rst          in   1            synchronous, active-high reset
//  PADDR        in   APB_AW       APB address
//  PSEL/PENABLE/PWRITE in 1       APB control
//  PWDATA       in   APB_DW       write data
//  PRDATA       out  APB_DW       read data; 0 when not in a read access phase
//  PREADY       out  1            access complete
//  PSLVERR      out  1            error; valid only with PREADY
//  key_o/nonce_o out 128          key and nonce, word 0 = bits [APB_DW-1:0]
//  ad_size_o/pt_size_o out DATA_AW  CTRL fields
//  delay_o      out  DELAY_WIDTH  CTRL field
//  start_o      out  1            one-cycle start pulse
//  ready_i      in   1            wrapper idle
//  tag_valid_i  in   1            wrapper tag valid
//  tag_i        in   128          tag
//  ad_push_o/pt_push_o out 1      one-cycle push; ad_o/pt_o out 64 = assembled block
//  ad_full_i/ad_empty_i/pt_full_i/pt_empty_i in 1   FIFO flags
//  ct_pop_o     out  1            one-cycle pop
//  ct_i         in   64           CT FIFO head
//  ct_full_i/ct_empty_i in 1      CT FIFO flags
//  irq_o        out  1            registered |(IRQ_STAT & IRQ_EN)
// BEHAVIOUR
//  Map (byte offsets):
//  - Control slots are 8 bytes: CTRL 0x00, STATUS 0x08 (RO), IRQ_EN 0x10, IRQ_STAT 0x18 (W1C).
//  - KEY 0x20, NONCE 0x30, TAG 0x40 (RO), AD 0x50, PT 0x58, CT 0x60 (RO).
//  - Address >= 0x68, unaligned address, or write to RO -> PSLVERR, no state change.
//  - At APB_DW=32, offset +4 of a control slot reads 0; a write there -> PSLVERR.
//  CTRL fields:
//  - [0] START: write 1 -> start_o pulses the next cycle; reads 0.
//  - [1] CLR_BLK: write 1 clears the partial AD/PT/CT beat masks; reads 0.
//  - [2 +: DATA_AW] AD size; [9 +: DATA_AW] PT size; [16 +: DELAY_WIDTH] delay.
//  STATUS[7:0] = {ct_full, ct_empty, pt_full, pt_empty, ad_full, ad_empty, tag_valid, ready}.
//  Busy lock: a write to CTRL/KEY/NONCE while ready_i=0 -> PSLVERR, no update.
//  Zero-wait accesses: PREADY = PSEL & PENABLE.
//  Back-pressure:
//  - Trigger: AD write with ad_full_i, PT write with pt_full_i, or CT read with ct_empty_i.
//  - PREADY stays low while the flag holds; the wait counter increments each stalled cycle.
//  - Flag clears -> the access completes normally on that cycle.
//  - Counter reaches WAIT_MAX -> PREADY=1, PSLVERR=1, no effect.
//  - Counter clears whenever PREADY=1 or PSEL=0.
//  Beat tracking:
//  - Each 64-bit window keeps a 64/APB_DW bit mask of beats accessed since the last push/pop.
//  - Rewriting a beat overwrites the data and does not advance the mask.
//  - Completing the final beat -> push/pop is high the cycle after the access phase.
//  - The mask clears in the same cycle as the push/pop.
//  - CT data is read live from ct_i. TAG is a snapshot latched on the tag_valid_i rising edge.
//  IRQ_STAT (sticky, W1C): bit0 DONE = tag_valid_i rise; bit1 CT_AVAIL = ct_empty_i fall;
//  bit2 BUS_ERR = any PSLVERR. When set and clear coincide, set wins.
//  Reset: every register, mask, counter and output is 0.
//  - While rst is high, PREADY = PSEL & PENABLE and PSLVERR = 0; no access commits.
//  - Reset mid-stall: the stall ends the same cycle.
// STRUCTURE
//  ascon_pack (existing) supplies u64_t/u128_t.
//  Add to it: region offset localparams, IRQ bit indices and a packed status_t.
//  Sub-module apb_blk_tracker(BEATS): beat mask, completion pulse and clear input;
//  instantiated for AD, PT and CT.
// TESTING
//  - Reset then read STATUS with ready_i=1, ad_empty_i=1 -> PRDATA=0x05, no wait state.
//  - APB_DW=32: write AD 0x54=0xDEADBEEF, then 0x50=0x01234567
//    -> ad_push_o single pulse, ad_o=0xDEADBEEF_01234567.
//  - ad_full_i=1 for 10 cycles during the final AD beat -> 10 wait states, then push.
//    Held full for WAIT_MAX -> PSLVERR, no push.
//  - Write CTRL=0x1 with ready_i=1 -> start_o high 1 cycle, CTRL reads 0.
//    Repeat with ready_i=0 -> PSLVERR.
//  - IRQ_EN=0x1, pulse tag_valid_i -> irq_o=1, TAG = tag_i snapshot.
//    Write IRQ_STAT=0x1 while a new rise occurs -> bit stays 1.
//  - rst asserted mid CT stall -> PREADY=1, PSLVERR=0, all outputs 0 the next cycle.

Source files
------------

// File: rtl/ascon_pack.sv
// Shared types for the Ascon subsystem, plus the APB register-map offsets,
// IRQ bit positions and the STATUS layout used by apb_ascon_csr.
package ascon_pack;

  typedef logic [63:0]  u64_t;
  typedef logic [127:0] u128_t;

  localparam logic [6:0] OFF_CTRL     = 7'h00;
  localparam logic [6:0] OFF_STATUS   = 7'h08;
  localparam logic [6:0] OFF_IRQ_EN   = 7'h10;
  localparam logic [6:0] OFF_IRQ_STAT = 7'h18;
  localparam logic [6:0] OFF_KEY      = 7'h20;
  localparam logic [6:0] OFF_NONCE    = 7'h30;
  localparam logic [6:0] OFF_TAG      = 7'h40;
  localparam logic [6:0] OFF_AD       = 7'h50;
  localparam logic [6:0] OFF_PT       = 7'h58;
  localparam logic [6:0] OFF_CT       = 7'h60;
  localparam logic [6:0] OFF_END      = 7'h68;

  localparam int IRQ_DONE     = 0;
  localparam int IRQ_CT_AVAIL = 1;
  localparam int IRQ_BUS_ERR  = 2;
  localparam int IRQ_W        = 3;

  typedef struct packed {
    logic ct_full;
    logic ct_empty;
    logic pt_full;
    logic pt_empty;
    logic ad_full;
    logic ad_empty;
    logic tag_valid;
    logic ready;
  } status_t;

endpackage

// File: rtl/apb_blk_tracker.sv
// Tracks which bus beats of one 64-bit window have been accessed and emits a
// one-cycle done pulse (with the mask cleared) once every beat has been seen.
module apb_blk_tracker #(
  parameter int BEATS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             hit,
  input  logic [BEATS-1:0] beat_oh,
  output logic             done
);

  logic [BEATS-1:0] mask_r;
  logic [BEATS-1:0] next_s;
  logic             full_s;
  logic             done_r;

  // Candidate mask after this cycle's access; re-hitting a beat leaves it unchanged
  always_comb begin
    next_s = mask_r;
    if (hit) begin
      next_s = mask_r | beat_oh;
    end else begin
      next_s = mask_r;
    end
    full_s = hit & (&next_s);
  end

  // Mask and done-pulse registers
  always_ff @(posedge clk) begin
    if (rst) begin
      mask_r <= '0;
      done_r <= 1'b0;
    end else begin
      done_r <= full_s;
      if (clr || full_s) begin
        mask_r <= '0;
      end else begin
        mask_r <= next_s;
      end
    end
  end

  assign done = done_r;

endmodule

// File: rtl/apb_ascon_csr.sv
// APB register bank for the Ascon wrapper: key/nonce/control, status, AD/PT
// block assembly, CT readout, tag snapshot and masked sticky interrupts.
module apb_ascon_csr
  import ascon_pack::*;
#(
  parameter int APB_AW      = 10,
  parameter int APB_DW      = 32,
  parameter int DATA_AW     = 7,
  parameter int DELAY_WIDTH = 16,
  parameter int WAIT_MAX    = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [APB_AW-1:0]      PADDR,
  input  logic                   PSEL,
  input  logic                   PENABLE,
  input  logic                   PWRITE,
  input  logic [APB_DW-1:0]      PWDATA,
  output logic [APB_DW-1:0]      PRDATA,
  output logic                   PREADY,
  output logic                   PSLVERR,
  output logic [127:0]           key_o,
  output logic [127:0]           nonce_o,
  output logic [DATA_AW-1:0]     ad_size_o,
  output logic [DATA_AW-1:0]     pt_size_o,
  output logic [DELAY_WIDTH-1:0] delay_o,
  output logic                   start_o,
  input  logic                   ready_i,
  input  logic                   tag_valid_i,
  input  logic [127:0]           tag_i,
  output logic                   ad_push_o,
  output logic [63:0]            ad_o,
  output logic                   pt_push_o,
  output logic [63:0]            pt_o,
  input  logic                   ad_full_i,
  input  logic                   ad_empty_i,
  input  logic                   pt_full_i,
  input  logic                   pt_empty_i,
  output logic                   ct_pop_o,
  input  logic [63:0]            ct_i,
  input  logic                   ct_full_i,
  input  logic                   ct_empty_i,
  output logic                   irq_o
);

  localparam int BEATS  = 64 / APB_DW;
  localparam int CW     = $clog2(WAIT_MAX + 1);
  localparam int CTRL_W = 16 + DELAY_WIDTH;

  if ((APB_DW != 32) && (APB_DW != 64)) begin : g_dw_check
    $error("apb_ascon_csr: APB_DW must be 32 or 64");
  end

  logic [CTRL_W-1:0] ctrl_r;
  u128_t             key_r, nonce_r, tag_r;
  u64_t              ad_r, pt_r;
  logic [IRQ_W-1:0]  irq_en_r, irq_stat_r;
  logic              irq_r, start_r, tag_valid_q_r, ct_empty_q_r;
  logic [CW-1:0]     wait_cnt_r;

  logic              access_s, valid_s, hi_half_s, ctl_slot_s;
  logic [6:0]        off_s;
  logic              is_ctrl_s, is_status_s, is_irq_en_s, is_irq_stat_s;
  logic              is_key_s, is_nonce_s, is_tag_s, is_ad_s, is_pt_s, is_ct_s;
  logic              err_s, stall_s, timeout_s, pready_s, pslverr_s;
  logic              commit_s, wr_commit_s, rd_commit_s, blk_clr_s;
  logic [6:0]        key_bit_s;
  logic [5:0]        blk_bit_s;
  logic [BEATS-1:0]  beat_oh_s;
  logic [APB_DW-1:0] rdata_s;
  logic [IRQ_W-1:0]  irq_set_s, w1c_s;
  status_t           status_s;

  assign status_s = '{ct_full: ct_full_i, ct_empty: ct_empty_i, pt_full: pt_full_i,
                      pt_empty: pt_empty_i, ad_full: ad_full_i, ad_empty: ad_empty_i,
                      tag_valid: tag_valid_i, ready: ready_i};

  // Address decode, error classification and wait-state control
  always_comb begin
    access_s      = PSEL & PENABLE;
    off_s         = PADDR[6:0];
    valid_s       = (PADDR < APB_AW'(OFF_END)) &&
                    ((PADDR[2:0] & 3'(APB_DW / 8 - 1)) == 3'd0);
    hi_half_s     = (APB_DW == 32) & off_s[2];
    is_ctrl_s     = valid_s & (off_s[6:3] == OFF_CTRL[6:3]);
    is_status_s   = valid_s & (off_s[6:3] == OFF_STATUS[6:3]);
    is_irq_en_s   = valid_s & (off_s[6:3] == OFF_IRQ_EN[6:3]);
    is_irq_stat_s = valid_s & (off_s[6:3] == OFF_IRQ_STAT[6:3]);
    is_key_s      = valid_s & (off_s[6:4] == OFF_KEY[6:4]);
    is_nonce_s    = valid_s & (off_s[6:4] == OFF_NONCE[6:4]);
    is_tag_s      = valid_s & (off_s[6:4] == OFF_TAG[6:4]);
    is_ad_s       = valid_s & (off_s[6:3] == OFF_AD[6:3]);
    is_pt_s       = valid_s & (off_s[6:3] == OFF_PT[6:3]);
    is_ct_s       = valid_s & (off_s[6:3] == OFF_CT[6:3]);
    ctl_slot_s    = is_ctrl_s | is_status_s | is_irq_en_s | is_irq_stat_s;
    key_bit_s     = {off_s[3:0], 3'b000};
    blk_bit_s     = {off_s[2:0], 3'b000};

    if (!valid_s) begin
      err_s = 1'b1;
    end else if (PWRITE) begin
      err_s = is_status_s | is_tag_s | is_ct_s | (ctl_slot_s & hi_half_s) |
              (~ready_i & (is_ctrl_s | is_key_s | is_nonce_s));
    end else begin
      err_s = 1'b0;
    end

    if (PWRITE) begin
      stall_s = access_s & ((is_ad_s & ad_full_i) | (is_pt_s & pt_full_i));
    end else begin
      stall_s = access_s & is_ct_s & ct_empty_i;
    end
    timeout_s   = stall_s & (wait_cnt_r == CW'(WAIT_MAX));
    pready_s    = access_s & (rst | ~stall_s | timeout_s);
    pslverr_s   = pready_s & ~rst & (err_s | timeout_s);
    commit_s    = pready_s & ~rst & ~err_s & ~timeout_s;
    wr_commit_s = commit_s & PWRITE;
    rd_commit_s = commit_s & ~PWRITE;
    blk_clr_s   = wr_commit_s & is_ctrl_s & PWDATA[1];

    w1c_s = (wr_commit_s & is_irq_stat_s) ? PWDATA[IRQ_W-1:0] : {IRQ_W{1'b0}};
    irq_set_s               = {IRQ_W{1'b0}};
    irq_set_s[IRQ_DONE]     = tag_valid_i & ~tag_valid_q_r;
    irq_set_s[IRQ_CT_AVAIL] = ~ct_empty_i & ct_empty_q_r;
    irq_set_s[IRQ_BUS_ERR]  = pslverr_s;
  end

  // Beat select within the 64-bit AD/PT/CT window
  always_comb begin
    beat_oh_s = '0;
    for (int b = 0; b < BEATS; b++) begin
      beat_oh_s[b] = (off_s[2:0] == 3'(b * (APB_DW / 8)));
    end
  end

  // Read-data mux; the upper word of a control slot on a 32-bit bus reads 0
  always_comb begin
    rdata_s = '0;
    if (ctl_slot_s && hi_half_s) begin
      rdata_s = '0;
    end else if (is_ctrl_s) begin
      rdata_s = APB_DW'(ctrl_r);
    end else if (is_status_s) begin
      rdata_s = APB_DW'(status_s);
    end else if (is_irq_en_s) begin
      rdata_s = APB_DW'(irq_en_r);
    end else if (is_irq_stat_s) begin
      rdata_s = APB_DW'(irq_stat_r);
    end else if (is_key_s) begin
      rdata_s = key_r[key_bit_s +: APB_DW];
    end else if (is_nonce_s) begin
      rdata_s = nonce_r[key_bit_s +: APB_DW];
    end else if (is_tag_s) begin
      rdata_s = tag_r[key_bit_s +: APB_DW];
    end else if (is_ad_s) begin
      rdata_s = ad_r[blk_bit_s +: APB_DW];
    end else if (is_pt_s) begin
      rdata_s = pt_r[blk_bit_s +: APB_DW];
    end else if (is_ct_s) begin
      rdata_s = ct_i[blk_bit_s +: APB_DW];
    end else begin
      rdata_s = '0;
    end
  end

  // Register state, edge detectors, sticky interrupts and wait counter
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_r        <= '0;
      key_r         <= '0;
      nonce_r       <= '0;
      tag_r         <= '0;
      ad_r          <= '0;
      pt_r          <= '0;
      irq_en_r      <= '0;
      irq_stat_r    <= '0;
      irq_r         <= 1'b0;
      start_r       <= 1'b0;
      tag_valid_q_r <= 1'b0;
      ct_empty_q_r  <= 1'b0;
      wait_cnt_r    <= '0;
    end else begin
      start_r <= wr_commit_s & is_ctrl_s & PWDATA[0];
      if (wr_commit_s && is_ctrl_s) ctrl_r <= {PWDATA[CTRL_W-1:2], 2'b00};
      if (wr_commit_s && is_irq_en_s) irq_en_r <= PWDATA[IRQ_W-1:0];
      if (wr_commit_s && is_key_s) key_r[key_bit_s +: APB_DW] <= PWDATA;
      if (wr_commit_s && is_nonce_s) nonce_r[key_bit_s +: APB_DW] <= PWDATA;
      if (wr_commit_s && is_ad_s) ad_r[blk_bit_s +: APB_DW] <= PWDATA;
      if (wr_commit_s && is_pt_s) pt_r[blk_bit_s +: APB_DW] <= PWDATA;
      if (irq_set_s[IRQ_DONE]) tag_r <= tag_i;
      tag_valid_q_r <= tag_valid_i;
      ct_empty_q_r  <= ct_empty_i;
      // set is OR-ed after the clear so a coincident event stays latched
      irq_stat_r    <= (irq_stat_r & ~w1c_s) | irq_set_s;
      irq_r         <= |(irq_stat_r & irq_en_r);
      if (!PSEL || pready_s) begin
        wait_cnt_r <= '0;
      end else if (stall_s) begin
        wait_cnt_r <= wait_cnt_r + CW'(1);
      end
    end
  end

  apb_blk_tracker #(.BEATS(BEATS)) u_ad_trk (
    .clk(clk), .rst(rst), .clr(blk_clr_s), .hit(wr_commit_s & is_ad_s),
    .beat_oh(beat_oh_s), .done(ad_push_o)
  );

  apb_blk_tracker #(.BEATS(BEATS)) u_pt_trk (
    .clk(clk), .rst(rst), .clr(blk_clr_s), .hit(wr_commit_s & is_pt_s),
    .beat_oh(beat_oh_s), .done(pt_push_o)
  );

  apb_blk_tracker #(.BEATS(BEATS)) u_ct_trk (
    .clk(clk), .rst(rst), .clr(blk_clr_s), .hit(rd_commit_s & is_ct_s),
    .beat_oh(beat_oh_s), .done(ct_pop_o)
  );

  assign PREADY    = pready_s;
  assign PSLVERR   = pslverr_s;
  assign PRDATA    = (access_s && !PWRITE && !rst) ? rdata_s : '0;
  assign key_o     = key_r;
  assign nonce_o   = nonce_r;
  assign ad_size_o = ctrl_r[2 +: DATA_AW];
  assign pt_size_o = ctrl_r[9 +: DATA_AW];
  assign delay_o   = ctrl_r[16 +: DELAY_WIDTH];
  assign start_o   = start_r;
  assign ad_o      = ad_r;
  assign pt_o      = pt_r;
  assign irq_o     = irq_r;

endmodule

// File: tb/tb_apb_ascon_csr.sv
// Directed bench for apb_ascon_csr (APB_DW=32): a vector table for the register
// map plus hand sequences for block push, back-pressure, IRQs and reset.
module tb_apb_ascon_csr;

  logic         clk = 1'b0;
  logic         rst;
  logic [9:0]   PADDR;
  logic         PSEL, PENABLE, PWRITE;
  logic [31:0]  PWDATA, PRDATA;
  logic         PREADY, PSLVERR;
  logic [127:0] key_o, nonce_o, tag_i;
  logic [6:0]   ad_size_o, pt_size_o;
  logic [15:0]  delay_o;
  logic         start_o, ready_i, tag_valid_i;
  logic         ad_push_o, pt_push_o, ct_pop_o, irq_o;
  logic [63:0]  ad_o, pt_o, ct_i;
  logic         ad_full_i, ad_empty_i, pt_full_i, pt_empty_i, ct_full_i, ct_empty_i;

  int n_cmp = 0;
  int n_bad = 0;
  int push_cnt = 0;
  int pop_cnt = 0;
  int start_cnt = 0;

  apb_ascon_csr dut (
    .clk(clk), .rst(rst), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR), .key_o(key_o), .nonce_o(nonce_o), .ad_size_o(ad_size_o),
    .pt_size_o(pt_size_o), .delay_o(delay_o), .start_o(start_o), .ready_i(ready_i),
    .tag_valid_i(tag_valid_i), .tag_i(tag_i), .ad_push_o(ad_push_o), .ad_o(ad_o),
    .pt_push_o(pt_push_o), .pt_o(pt_o), .ad_full_i(ad_full_i), .ad_empty_i(ad_empty_i),
    .pt_full_i(pt_full_i), .pt_empty_i(pt_empty_i), .ct_pop_o(ct_pop_o), .ct_i(ct_i),
    .ct_full_i(ct_full_i), .ct_empty_i(ct_empty_i), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ad_push_o) push_cnt++;
    if (ct_pop_o) pop_cnt++;
    if (start_o) start_cnt++;
  end

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic apb_xfer(input logic wr, input logic [9:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rd, output logic err, output int waits);
    @(posedge clk); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    waits = 0;
    rd = 32'h0;
    err = 1'b0;
    forever begin
      @(negedge clk);
      if (PREADY) begin
        rd = PRDATA;
        err = PSLVERR;
        break;
      end
      waits++;
      if (waits > 200) begin
        n_cmp++;
        n_bad++;
        $display("FAIL apb_timeout: addr %0h waited %0d cycles, required PREADY", addr, waits);
        break;
      end
    end
    @(posedge clk); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  typedef struct {
    logic        wr;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t         vecs[$];
  logic [31:0]  rd;
  logic         err;
  int           waits;
  int           base;
  logic [127:0] tag_a;

  initial begin
    rst = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 10'h0; PWDATA = 32'h0;
    ready_i = 1'b1; tag_valid_i = 1'b0; tag_i = 128'h0; ct_i = 64'h11223344_55667788;
    ad_full_i = 1'b0; ad_empty_i = 1'b1; pt_full_i = 1'b0; pt_empty_i = 1'b0;
    ct_full_i = 1'b0; ct_empty_i = 1'b0;

    vecs.push_back('{1'b0, 10'h008, 32'h0,        32'h00000005, 1'b0});
    vecs.push_back('{1'b0, 10'h00C, 32'h0,        32'h00000000, 1'b0});
    vecs.push_back('{1'b1, 10'h00C, 32'h1,        32'h00000000, 1'b1});
    vecs.push_back('{1'b1, 10'h020, 32'h11111111, 32'h00000000, 1'b0});
    vecs.push_back('{1'b1, 10'h02C, 32'h44444444, 32'h00000000, 1'b0});
    vecs.push_back('{1'b0, 10'h02C, 32'h0,        32'h44444444, 1'b0});
    vecs.push_back('{1'b0, 10'h020, 32'h0,        32'h11111111, 1'b0});
    vecs.push_back('{1'b0, 10'h024, 32'h0,        32'h00000000, 1'b0});
    vecs.push_back('{1'b1, 10'h034, 32'hCAFEF00D, 32'h00000000, 1'b0});
    vecs.push_back('{1'b0, 10'h034, 32'h0,        32'hCAFEF00D, 1'b0});
    vecs.push_back('{1'b1, 10'h008, 32'h5,        32'h00000000, 1'b1});
    vecs.push_back('{1'b0, 10'h068, 32'h0,        32'h00000000, 1'b1});
    vecs.push_back('{1'b0, 10'h3FC, 32'h0,        32'h00000000, 1'b1});
    vecs.push_back('{1'b0, 10'h002, 32'h0,        32'h00000000, 1'b1});
    vecs.push_back('{1'b1, 10'h010, 32'hFFFFFFFF, 32'h00000000, 1'b0});
    vecs.push_back('{1'b0, 10'h010, 32'h0,        32'h00000007, 1'b0});
    vecs.push_back('{1'b1, 10'h000, 32'h12345678, 32'h00000000, 1'b0});
    vecs.push_back('{1'b0, 10'h000, 32'h0,        32'h12345678, 1'b0});
    vecs.push_back('{1'b0, 10'h004, 32'h0,        32'h00000000, 1'b0});
    vecs.push_back('{1'b0, 10'h060, 32'h0,        32'h55667788, 1'b0});
    vecs.push_back('{1'b0, 10'h064, 32'h0,        32'h11223344, 1'b0});
    vecs.push_back('{1'b1, 10'h060, 32'h1,        32'h00000000, 1'b1});
    vecs.push_back('{1'b1, 10'h040, 32'h1,        32'h00000000, 1'b1});

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_key", key_o, 128'h0);
    check("rst_irq", {127'h0, irq_o}, 128'h0);
    check("rst_start", {127'h0, start_o}, 128'h0);
    check("rst_pready", {127'h0, PREADY}, 128'h0);
    check("rst_prdata", {96'h0, PRDATA}, 128'h0);

    apb_xfer(1'b0, 10'h008, 32'h0, rd, err, waits);
    check("status_rd", {96'h0, rd}, 128'h5);
    check("status_waits", 128'(waits), 128'h0);

    // register-map vector table
    for (int i = 0; i < vecs.size(); i++) begin
      apb_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, err, waits);
      check($sformatf("vec%0d_err", i), {127'h0, err}, {127'h0, vecs[i].exp_err});
      if (!vecs[i].wr) check($sformatf("vec%0d_rdata", i), {96'h0, rd}, {96'h0, vecs[i].exp_rd});
    end
    check("ad_size", {121'h0, ad_size_o}, 128'h1E);
    check("pt_size", {121'h0, pt_size_o}, 128'h2B);
    check("delay", {112'h0, delay_o}, 128'h1234);
    check("key_o", key_o, 128'h44444444_00000000_00000000_11111111);
    check("nonce_o", nonce_o, 128'h00000000_00000000_CAFEF00D_00000000);
    check("ct_pop_cnt", 128'(pop_cnt), 128'd1);
    apb_xfer(1'b0, 10'h018, 32'h0, rd, err, waits);
    check("irq_stat_buserr", {96'h0, rd}, 128'h4);
    check("irq_o_buserr", {127'h0, irq_o}, 128'h1);

    // AD assembly, then a rewrite of beat 0 before completion
    base = push_cnt;
    apb_xfer(1'b1, 10'h054, 32'hDEADBEEF, rd, err, waits);
    check("ad_push_early", {127'h0, ad_push_o}, 128'h0);
    apb_xfer(1'b1, 10'h050, 32'h01234567, rd, err, waits);
    check("ad_push", {127'h0, ad_push_o}, 128'h1);
    check("ad_o", {64'h0, ad_o}, {64'h0, 64'hDEADBEEF_01234567});
    @(posedge clk); #1;
    check("ad_push_end", {127'h0, ad_push_o}, 128'h0);
    check("ad_push_cnt1", 128'(push_cnt - base), 128'd1);
    apb_xfer(1'b1, 10'h050, 32'hAAAA0000, rd, err, waits);
    apb_xfer(1'b1, 10'h050, 32'hBBBB1111, rd, err, waits);
    check("ad_rewrite_nopush", 128'(push_cnt - base), 128'd1);
    apb_xfer(1'b1, 10'h054, 32'hCCCC2222, rd, err, waits);
    check("ad_o_rewrite", {64'h0, ad_o}, {64'h0, 64'hCCCC2222_BBBB1111});

    // back-pressure: 10 stalled cycles then completion
    apb_xfer(1'b1, 10'h054, 32'h0000AAAA, rd, err, waits);
    base = push_cnt;
    ad_full_i = 1'b1;
    fork
      apb_xfer(1'b1, 10'h050, 32'h0000BBBB, rd, err, waits);
      begin
        @(posedge clk); @(posedge clk);
        repeat (10) @(posedge clk);
        #1 ad_full_i = 1'b0;
      end
    join
    check("bp_waits", 128'(waits), 128'd10);
    check("bp_err", {127'h0, err}, 128'h0);
    check("bp_push", {127'h0, ad_push_o}, 128'h1);
    check("bp_ad_o", {64'h0, ad_o}, {64'h0, 64'h0000AAAA_0000BBBB});

    // held full: timeout error, no push, then CLR_BLK discards the partial beat
    apb_xfer(1'b1, 10'h054, 32'h12121212, rd, err, waits);
    base = push_cnt;
    ad_full_i = 1'b1;
    apb_xfer(1'b1, 10'h050, 32'h34343434, rd, err, waits);
    ad_full_i = 1'b0;
    check("to_waits", 128'(waits), 128'd64);
    check("to_err", {127'h0, err}, 128'h1);
    check("to_nopush", 128'(push_cnt - base), 128'd0);
    apb_xfer(1'b1, 10'h000, 32'h2, rd, err, waits);
    apb_xfer(1'b1, 10'h050, 32'h56565656, rd, err, waits);
    check("clr_nopush", {127'h0, ad_push_o}, 128'h0);
    apb_xfer(1'b1, 10'h054, 32'h78787878, rd, err, waits);
    check("clr_push", {127'h0, ad_push_o}, 128'h1);
    check("clr_ad_o", {64'h0, ad_o}, {64'h0, 64'h78787878_56565656});

    // START pulse and busy lock
    base = start_cnt;
    apb_xfer(1'b1, 10'h000, 32'h1, rd, err, waits);
    check("start_hi", {127'h0, start_o}, 128'h1);
    @(posedge clk); #1;
    check("start_lo", {127'h0, start_o}, 128'h0);
    check("start_cnt", 128'(start_cnt - base), 128'd1);
    apb_xfer(1'b0, 10'h000, 32'h0, rd, err, waits);
    check("ctrl_rd0", {96'h0, rd}, 128'h0);
    ready_i = 1'b0;
    apb_xfer(1'b1, 10'h000, 32'h1, rd, err, waits);
    check("busy_ctrl_err", {127'h0, err}, 128'h1);
    apb_xfer(1'b1, 10'h020, 32'h99999999, rd, err, waits);
    check("busy_key_err", {127'h0, err}, 128'h1);
    repeat (2) @(posedge clk); #1;
    check("busy_nostart", 128'(start_cnt - base), 128'd1);
    check("busy_key_kept", key_o, 128'h44444444_00000000_00000000_11111111);
    ready_i = 1'b1;

    // DONE interrupt and tag snapshot
    apb_xfer(1'b1, 10'h018, 32'h7, rd, err, waits);
    apb_xfer(1'b1, 10'h010, 32'h1, rd, err, waits);
    tag_a = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    tag_i = tag_a;
    @(posedge clk); #1 tag_valid_i = 1'b1;
    @(posedge clk); #1 tag_valid_i = 1'b0;
    tag_i = 128'hFFFF0000_FFFF0000_FFFF0000_FFFF0000;
    repeat (3) @(posedge clk); #1;
    check("irq_done", {127'h0, irq_o}, 128'h1);
    apb_xfer(1'b0, 10'h018, 32'h0, rd, err, waits);
    check("irq_stat_done", {96'h0, rd}, 128'h1);
    for (int i = 0; i < 4; i++) begin
      apb_xfer(1'b0, 10'(32'h40 + 4 * i), 32'h0, rd, err, waits);
      check($sformatf("tag_w%0d", i), {96'h0, rd}, {96'h0, tag_a[32 * i +: 32]});
    end
    fork
      apb_xfer(1'b1, 10'h018, 32'h1, rd, err, waits);
      begin
        @(posedge clk); @(posedge clk);
        #1 tag_valid_i = 1'b1;
      end
    join
    apb_xfer(1'b0, 10'h018, 32'h0, rd, err, waits);
    check("irq_set_wins", {96'h0, rd}, 128'h1);
    apb_xfer(1'b1, 10'h018, 32'h1, rd, err, waits);
    apb_xfer(1'b0, 10'h018, 32'h0, rd, err, waits);
    check("irq_w1c", {96'h0, rd}, 128'h0);
    apb_xfer(1'b1, 10'h040, 32'h0, rd, err, waits);
    apb_xfer(1'b0, 10'h018, 32'h0, rd, err, waits);
    check("irq_stat_err", {96'h0, rd}, 128'h4);
    repeat (3) @(posedge clk); #1;
    check("irq_masked", {127'h0, irq_o}, 128'h0);

    // reset asserted during a CT stall
    ct_empty_i = 1'b1;
    fork
      apb_xfer(1'b0, 10'h060, 32'h0, rd, err, waits);
      begin
        @(posedge clk); @(posedge clk);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
      end
    join
    check("rst_stall_waits", 128'(waits), 128'd5);
    check("rst_stall_err", {127'h0, err}, 128'h0);
    check("rst_stall_key", key_o, 128'h0);
    check("rst_stall_ad", {64'h0, ad_o}, 128'h0);
    check("rst_stall_ctrl", {96'h0, delay_o, 2'b00, pt_size_o, ad_size_o}, 128'h0);
    check("rst_stall_pulses", {125'h0, start_o, ad_push_o, ct_pop_o}, 128'h0);
    #1 rst = 1'b0;
    ct_empty_i = 1'b0;
    apb_xfer(1'b0, 10'h02C, 32'h0, rd, err, waits);
    check("post_rst_key_rd", {96'h0, rd}, 128'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
